// File: rtl/mem_arb_pkg.sv
// Shared state encoding, memory access-size codes and default watchdog limit
// for the mem_arbiter slice.
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t FETCH = 2'd1;
    localparam state_t DATA  = 2'd2;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_HALF = 2'b01;
    localparam logic [1:0] MODE_BYTE = 2'b10;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-port signals of mem_arbiter. The slave modport is the
// arbiter's view; master is the CPU/memory environment around it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              fetchReq;
    logic [ADDR_W-1:0] fetchAddr;
    logic [DATA_W-1:0] inst;
    logic              fetchDone;

    logic              dataRead;
    logic              dataWrite;
    logic [ADDR_W-1:0] dataAddr;
    logic [DATA_W-1:0] dataWData;
    logic [1:0]        dataMode;
    logic [DATA_W-1:0] readMemData;
    logic              dataDone;

    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWData;
    logic              memRd;
    logic              memWr;
    logic [1:0]        memMode;
    logic [DATA_W-1:0] memRData;
    logic              memReady;
    logic              busError;

    modport slave (
        input  fetchReq, fetchAddr, dataRead, dataWrite, dataAddr, dataWData,
               dataMode, memRData, memReady,
        output inst, fetchDone, readMemData, dataDone, memAddr, memWData,
               memRd, memWr, memMode, busError
    );

    modport master (
        output fetchReq, fetchAddr, dataRead, dataWrite, dataAddr, dataWData,
               dataMode, memRData, memReady,
        input  inst, fetchDone, readMemData, dataDone, memAddr, memWData,
               memRd, memWr, memMode, busError
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog counter; expired is high in the last cycle a transaction
// may wait, so the abort lands after exactly LIMIT busy cycles.
module mem_arb_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int              CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing one variable-latency memory port between the
// fetch and data requesters. Define MEM_ARB_TIMEOUT_EN to add the watchdog abort.
//   state | meaning
//   IDLE  | port free; data beats fetch, a requester in its done cycle is skipped
//   FETCH | instruction read outstanding, strobes held until memReady
//   DATA  | load or store outstanding, strobes held until memReady
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    state_t state;
    logic   busy;
    logic   finish;
    logic   abort;
    logic   data_pend;
    logic   fetch_pend;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT must be at least 1");
    end

    assign busy       = (state != IDLE);
    assign data_pend  = (bus.dataRead | bus.dataWrite) & ~bus.dataDone;
    assign fetch_pend = bus.fetchReq & ~bus.fetchDone;

`ifdef MEM_ARB_TIMEOUT_EN
    logic grant;
    logic expired;

    assign grant = ~busy & (data_pend | fetch_pend);

    mem_arb_timer #(.LIMIT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (grant),
        .enable  (busy & ~bus.memReady),
        .expired (expired)
    );

    // memReady in the expiry cycle still counts as a normal completion
    assign abort = busy & ~bus.memReady & expired;
`else
    assign abort = 1'b0;
`endif

    assign finish = busy & (bus.memReady | abort);

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bus.memRd       <= 1'b0;
            bus.memWr       <= 1'b0;
            bus.memAddr     <= {ADDR_W{1'b0}};
            bus.memWData    <= {DATA_W{1'b0}};
            bus.memMode     <= MODE_WORD;
            bus.inst        <= {DATA_W{1'b0}};
            bus.readMemData <= {DATA_W{1'b0}};
            bus.fetchDone   <= 1'b0;
            bus.dataDone    <= 1'b0;
            bus.busError    <= 1'b0;
        end else begin
            bus.fetchDone <= 1'b0;
            bus.dataDone  <= 1'b0;
            bus.busError  <= 1'b0;
            case (state)
                IDLE: begin
                    if (data_pend) begin
                        state        <= DATA;
                        bus.memAddr  <= bus.dataAddr;
                        bus.memWData <= bus.dataWData;
                        bus.memMode  <= bus.dataMode;
                        bus.memRd    <= bus.dataRead;
                        bus.memWr    <= bus.dataWrite & ~bus.dataRead;
                    end else if (fetch_pend) begin
                        state       <= FETCH;
                        bus.memAddr <= bus.fetchAddr;
                        bus.memMode <= MODE_WORD;
                        bus.memRd   <= 1'b1;
                        bus.memWr   <= 1'b0;
                    end
                end
                FETCH, DATA: begin
                    if (finish) begin
                        state        <= IDLE;
                        bus.memRd    <= 1'b0;
                        bus.memWr    <= 1'b0;
                        bus.busError <= abort;
                        if (state == FETCH) begin
                            bus.fetchDone <= 1'b1;
                            bus.inst      <= abort ? {DATA_W{1'b0}} : bus.memRData;
                        end else begin
                            bus.dataDone <= 1'b1;
                            if (bus.memRd) begin
                                bus.readMemData <= abort ? {DATA_W{1'b0}} : bus.memRData;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
